// File: rtl/systolic_feeder_3x3_if.sv
// systolic_feeder_3x3_if
//   Bundles the row-load handshake and the skewed stream outputs of the
//   3x3 systolic feeder.
//   Load side : in_valid / in_ready handshake, in_a_row / in_b_row (3 lanes of DW).
//   Stream    : a_out / b_out (3 lanes of DW), out_valid, out_first, out_last.
//   Status    : busy.
//   Modports  : master = producer / consumer side, slave = feeder side.
interface systolic_feeder_3x3_if #(
    parameter int DW = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [3*DW-1:0] in_a_row;
    logic [3*DW-1:0] in_b_row;
    logic [3*DW-1:0] a_out;
    logic [3*DW-1:0] b_out;
    logic            out_valid;
    logic            out_first;
    logic            out_last;
    logic            busy;

    modport master (
        output in_valid, in_a_row, in_b_row,
        input  in_ready, a_out, b_out, out_valid, out_first, out_last, busy
    );

    modport slave (
        input  in_valid, in_a_row, in_b_row,
        output in_ready, a_out, b_out, out_valid, out_first, out_last, busy
    );
endinterface

// File: rtl/systolic_feeder_3x3.sv
// systolic_feeder_3x3
//   Ping-pong buffer plus diagonal skew in front of a 3x3 systolic array.
//   Rows of A and B are loaded one per handshake beat into the write bank.
//   A full bank is streamed over 5 steps: at step t, lane i of a_out carries
//   A[i][t-i] and lane j of b_out carries B[t-j][j], and out-of-range lanes are 0.
//   Loading the other bank overlaps streaming, so pairs run back to back.
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : systolic_feeder_3x3_if.slave (load handshake, stream outputs, busy)
module systolic_feeder_3x3 #(
    parameter int DW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    systolic_feeder_3x3_if.slave bus
);
    localparam int RW = 3 * DW;

    typedef enum logic {IDLE, STREAM} state_t;
    typedef logic [2:0][RW-1:0] mat_t;   // [row] -> packed row, element k at k*DW

    mat_t a_bank [2];
    mat_t b_bank [2];

    logic [1:0] full;
    logic       wr_bank;
    logic       rd_bank;
    logic [1:0] row_cnt;

    state_t     state, state_n;
    logic [2:0] t, t_n;
    logic       go;         // a stream step is presented after this edge
    logic       sel;        // bank supplying that step
    logic       done;       // current step is t=4: release rd_bank

    logic          accept;
    logic          load_done;
    logic [RW-1:0] a_q, b_q;
    logic          valid_q, first_q, last_q;

    // Lane i of the A stream at step s is A[i][k] with i+k == s.
    function automatic logic [RW-1:0] skew_a(input mat_t m, input logic [2:0] s);
        logic [RW-1:0] r;
        r = '0;
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 3; k++)
                if (int'(s) == i + k) r[i*DW +: DW] = m[i][k*DW +: DW];
        return r;
    endfunction

    // Lane j of the B stream at step s is B[k][j] with k+j == s.
    function automatic logic [RW-1:0] skew_b(input mat_t m, input logic [2:0] s);
        logic [RW-1:0] r;
        r = '0;
        for (int j = 0; j < 3; j++)
            for (int k = 0; k < 3; k++)
                if (int'(s) == j + k) r[j*DW +: DW] = m[k][j*DW +: DW];
        return r;
    endfunction

    assign bus.in_ready  = ~full[wr_bank];
    assign accept        = bus.in_valid & ~full[wr_bank];
    assign load_done     = accept & (row_cnt == 2'd2);

    assign bus.a_out     = a_q;
    assign bus.b_out     = b_q;
    assign bus.out_valid = valid_q;
    assign bus.out_first = first_q;
    assign bus.out_last  = last_q;
    assign bus.busy      = (state == STREAM) | full[0] | full[1];

    // Bank storage carries no reset; the full flags alone say what is valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_bank[wr_bank][row_cnt] <= bus.in_a_row;
            b_bank[wr_bank][row_cnt] <= bus.in_b_row;
        end
    end

    // Loader pointers and bank ownership. The loader only writes a bank whose
    // full flag is clear and the streamer only reads a full bank, so the set
    // and clear below never target the same bank in one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            row_cnt <= 2'd0;
        end else begin
            if (accept) begin
                if (row_cnt == 2'd2) begin
                    row_cnt <= 2'd0;
                    wr_bank <= ~wr_bank;
                end else begin
                    row_cnt <= row_cnt + 2'd1;
                end
            end
            if (done) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
            if (load_done) full[wr_bank] <= 1'b1;
        end
    end

    // Streamer state register; t is the step currently on the outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            t     <= 3'd0;
        end else begin
            state <= state_n;
            t     <= t_n;
        end
    end

    always_comb begin
        state_n = state;
        t_n     = t;
        go      = 1'b0;
        sel     = rd_bank;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (full[rd_bank]) begin
                    state_n = STREAM;
                    t_n     = 3'd0;
                    go      = 1'b1;
                end
            end
            STREAM: begin
                if (t == 3'd4) begin
                    done = 1'b1;
                    // Other bank already loaded: chain straight into its t=0.
                    if (full[~rd_bank]) begin
                        t_n = 3'd0;
                        go  = 1'b1;
                        sel = ~rd_bank;
                    end else begin
                        state_n = IDLE;
                        t_n     = 3'd0;
                    end
                end else begin
                    t_n = t + 3'd1;
                    go  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                t_n     = 3'd0;
            end
        endcase
    end

    // Registered stream outputs for the step entered at this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (go) begin
            a_q     <= skew_a(a_bank[sel], t_n);
            b_q     <= skew_b(b_bank[sel], t_n);
            valid_q <= 1'b1;
            first_q <= (t_n == 3'd0);
            last_q  <= (t_n == 3'd4);
        end else begin
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_systolic_feeder_3x3.sv
module tb_systolic_feeder_3x3;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    systolic_feeder_3x3_if #(.DW(DW)) bus_if ();
    systolic_feeder_3x3 #(.DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus_if));

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Captured stream steps (sampled on the falling edge).
    logic [23:0] cap_a [$];
    logic [23:0] cap_b [$];
    logic        cap_f [$];
    logic        cap_l [$];
    int          cap_c [$];

    // Matrix slots: [slot][row][col]
    logic [7:0] ma [6][3][3];
    logic [7:0] mb [6][3][3];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus_if.out_valid === 1'b1) begin
            cap_a.push_back(bus_if.a_out);
            cap_b.push_back(bus_if.b_out);
            cap_f.push_back(bus_if.out_first);
            cap_l.push_back(bus_if.out_last);
            cap_c.push_back(cyc);
        end
    end

    function automatic logic [23:0] row_a(int m, int r);
        return {ma[m][r][2], ma[m][r][1], ma[m][r][0]};
    endfunction

    function automatic logic [23:0] row_b(int m, int r);
        return {mb[m][r][2], mb[m][r][1], mb[m][r][0]};
    endfunction

    // Skewed operand expected at step t: lane i = A[i][t-i], lane j = B[t-j][j].
    function automatic logic [23:0] exp_a(int m, int t);
        logic [23:0] r;
        r = '0;
        for (int i = 0; i < 3; i++)
            if (t - i >= 0 && t - i <= 2) r[i*8 +: 8] = ma[m][i][t-i];
        return r;
    endfunction

    function automatic logic [23:0] exp_b(int m, int t);
        logic [23:0] r;
        r = '0;
        for (int j = 0; j < 3; j++)
            if (t - j >= 0 && t - j <= 2) r[j*8 +: 8] = mb[m][t-j][j];
        return r;
    endfunction

    task automatic clear_caps();
        cap_a.delete(); cap_b.delete(); cap_f.delete(); cap_l.delete(); cap_c.delete();
    endtask

    // Offer one beat; returns the cycle count seen just before the accepting
    // edge (-1 if never accepted) and how many cycles it waited on in_ready.
    task automatic put(input logic [23:0] a, input logic [23:0] b,
                       output int acc, output int waits);
        bit got;
        got   = 1'b0;
        acc   = -1;
        waits = 0;
        bus_if.in_valid = 1'b1;
        bus_if.in_a_row = a;
        bus_if.in_b_row = b;
        while (!got && waits < 40) begin
            @(negedge clk);
            if (bus_if.in_ready === 1'b1) begin
                acc = cyc;
                got = 1'b1;
            end else begin
                waits++;
            end
            @(posedge clk); #1;
        end
        bus_if.in_valid = 1'b0;
    endtask

    task automatic wait_caps(input int n, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 80 && !ok; c++) begin
            @(negedge clk); #1;
            if (cap_a.size() >= n) ok = 1'b1;
        end
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        checks++; if (bus_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus_if.in_ready); end
        checks++; if (bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus_if.out_valid); end
        checks++; if (bus_if.a_out !== 24'h0 || bus_if.b_out !== 24'h0) begin errors++; $display("FAIL reset_data: got a=%h b=%h want 0", bus_if.a_out, bus_if.b_out); end
        checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus_if.busy); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus_if.out_valid !== 1'b0 || bus_if.busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: valid=%b busy=%b want 0/0", bus_if.out_valid, bus_if.busy); end
    endtask

    task automatic test_single();
        logic [23:0] ea [5];
        logic [23:0] eb [5];
        int acc, w;
        bit ok;
        ea[0] = 24'h000001; ea[1] = 24'h000402; ea[2] = 24'h070503; ea[3] = 24'h080600; ea[4] = 24'h090000;
        eb[0] = 24'h000001; eb[1] = 24'h000000; eb[2] = 24'h000100; eb[3] = 24'h000000; eb[4] = 24'h010000;
        clear_caps();
        for (int r = 0; r < 3; r++) put(row_a(4, r), row_b(4, r), acc, w);
        wait_caps(5, ok);
        checks++; if (!ok || cap_a.size() != 5) begin errors++; $display("FAIL single_count: got %0d steps want 5", cap_a.size()); end
        if (cap_a.size() >= 5) begin
            checks++; if (cap_c[0] !== acc + 2) begin errors++; $display("FAIL single_latency: got cycle %0d want %0d", cap_c[0], acc + 2); end
            for (int t = 0; t < 5; t++) begin
                checks++; if (cap_a[t] !== ea[t]) begin errors++; $display("FAIL single_a t=%0d: got %h want %h", t, cap_a[t], ea[t]); end
                checks++; if (cap_b[t] !== eb[t]) begin errors++; $display("FAIL single_b t=%0d: got %h want %h", t, cap_b[t], eb[t]); end
                checks++; if (cap_f[t] !== (t == 0) || cap_l[t] !== (t == 4)) begin errors++; $display("FAIL single_flags t=%0d: got first=%b last=%b", t, cap_f[t], cap_l[t]); end
            end
        end
        checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b want 0", bus_if.busy); end
    endtask

    task automatic test_back_to_back();
        int slots [2];
        int acc, w;
        bit ok;
        slots[0] = 4; slots[1] = 0;
        clear_caps();
        for (int s = 0; s < 2; s++)
            for (int r = 0; r < 3; r++) put(row_a(slots[s], r), row_b(slots[s], r), acc, w);
        wait_caps(10, ok);
        checks++; if (!ok || cap_a.size() != 10) begin errors++; $display("FAIL b2b_count: got %0d steps want 10", cap_a.size()); end
        if (cap_a.size() >= 10) begin
            checks++; if (cap_c[9] - cap_c[0] !== 9) begin errors++; $display("FAIL b2b_contiguous: got span %0d want 9", cap_c[9] - cap_c[0]); end
            checks++; if (cap_l[4] !== 1'b1 || cap_f[5] !== 1'b1) begin errors++; $display("FAIL b2b_seam: got last4=%b first5=%b want 1/1", cap_l[4], cap_f[5]); end
            for (int s = 0; s < 2; s++)
                for (int t = 0; t < 5; t++) begin
                    checks++;
                    if (cap_a[s*5+t] !== exp_a(slots[s], t) || cap_b[s*5+t] !== exp_b(slots[s], t)) begin
                        errors++;
                        $display("FAIL b2b_data s=%0d t=%0d: got a=%h b=%h want a=%h b=%h", s, t,
                                 cap_a[s*5+t], cap_b[s*5+t], exp_a(slots[s], t), exp_b(slots[s], t));
                    end
                end
        end
    endtask

    task automatic test_backpressure();
        int acc, w;
        int first_stall;
        bit ok;
        first_stall = -1;
        clear_caps();
        for (int n = 0; n < 12; n++) begin
            put(row_a(n / 3, n % 3), row_b(n / 3, n % 3), acc, w);
            if (w > 0 && first_stall < 0) first_stall = n;
            checks++; if (acc < 0) begin errors++; $display("FAIL bp_accept beat=%0d: got no accept want accept", n); end
        end
        checks++; if (first_stall !== 6) begin errors++; $display("FAIL bp_first_stall: got beat %0d want 6", first_stall); end
        wait_caps(20, ok);
        checks++; if (!ok || cap_a.size() != 20) begin errors++; $display("FAIL bp_count: got %0d steps want 20", cap_a.size()); end
        if (cap_a.size() >= 20)
            for (int s = 0; s < 4; s++)
                for (int t = 0; t < 5; t++) begin
                    checks++;
                    if (cap_a[s*5+t] !== exp_a(s, t) || cap_b[s*5+t] !== exp_b(s, t)) begin
                        errors++;
                        $display("FAIL bp_data s=%0d t=%0d: got a=%h b=%h want a=%h b=%h", s, t,
                                 cap_a[s*5+t], cap_b[s*5+t], exp_a(s, t), exp_b(s, t));
                    end
                end
    endtask

    task automatic test_gapped();
        int acc, w;
        bit ok;
        clear_caps();
        for (int r = 0; r < 3; r++) begin
            put(row_a(1, r), row_b(1, r), acc, w);
            if (r < 2) begin @(posedge clk); #1; end
        end
        wait_caps(5, ok);
        checks++; if (!ok || cap_a.size() != 5) begin errors++; $display("FAIL gap_count: got %0d steps want 5", cap_a.size()); end
        if (cap_a.size() >= 5) begin
            checks++; if (cap_c[0] !== acc + 2) begin errors++; $display("FAIL gap_latency: got cycle %0d want %0d", cap_c[0], acc + 2); end
            for (int t = 0; t < 5; t++) begin
                checks++;
                if (cap_a[t] !== exp_a(1, t) || cap_b[t] !== exp_b(1, t)) begin
                    errors++;
                    $display("FAIL gap_data t=%0d: got a=%h b=%h want a=%h b=%h", t, cap_a[t], cap_b[t], exp_a(1, t), exp_b(1, t));
                end
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        int acc, w;
        bit ok;
        clear_caps();
        for (int r = 0; r < 3; r++) put(row_a(5, r), row_b(5, r), acc, w);
        ok = 1'b0;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge clk); #1;
            if (cap_a.size() >= 3) ok = 1'b1;
        end
        checks++; if (!ok) begin errors++; $display("FAIL rms_reach_t2: got %0d steps want 3", cap_a.size()); end
        rst = 1'b0;
        #1;
        checks++;
        if (bus_if.out_valid !== 1'b0 || bus_if.out_first !== 1'b0 || bus_if.out_last !== 1'b0 ||
            bus_if.a_out !== 24'h0 || bus_if.b_out !== 24'h0 || bus_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL rms_outputs_zero: got valid=%b first=%b last=%b a=%h b=%h busy=%b want all 0",
                     bus_if.out_valid, bus_if.out_first, bus_if.out_last, bus_if.a_out, bus_if.b_out, bus_if.busy);
        end
        checks++; if (bus_if.in_ready !== 1'b1) begin errors++; $display("FAIL rms_in_ready: got %b want 1", bus_if.in_ready); end
        @(posedge clk); #1;
        checks++; if (bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL rms_held: got valid=%b want 0", bus_if.out_valid); end
        rst = 1'b1;
        clear_caps();
        for (int r = 0; r < 3; r++) put(row_a(2, r), row_b(2, r), acc, w);
        wait_caps(5, ok);
        checks++; if (!ok || cap_a.size() != 5) begin errors++; $display("FAIL rms_count: got %0d steps want 5", cap_a.size()); end
        if (cap_a.size() >= 5)
            for (int t = 0; t < 5; t++) begin
                checks++;
                if (cap_a[t] !== exp_a(2, t) || cap_b[t] !== exp_b(2, t)) begin
                    errors++;
                    $display("FAIL rms_data t=%0d: got a=%h b=%h want a=%h b=%h", t, cap_a[t], cap_b[t], exp_a(2, t), exp_b(2, t));
                end
            end
    endtask

    task automatic test_reset_mid_load();
        int acc, w;
        bit ok;
        clear_caps();
        for (int r = 0; r < 2; r++) put(row_a(5, r), row_b(5, r), acc, w);
        rst = 1'b0;
        #1;
        checks++; if (bus_if.in_ready !== 1'b1 || bus_if.busy !== 1'b0) begin errors++; $display("FAIL rml_state: got ready=%b busy=%b want 1/0", bus_if.in_ready, bus_if.busy); end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int r = 0; r < 3; r++) put(row_a(3, r), row_b(3, r), acc, w);
        wait_caps(5, ok);
        checks++; if (!ok || cap_a.size() != 5) begin errors++; $display("FAIL rml_count: got %0d steps want 5", cap_a.size()); end
        if (cap_a.size() >= 5)
            for (int t = 0; t < 5; t++) begin
                checks++;
                if (cap_a[t] !== exp_a(3, t) || cap_b[t] !== exp_b(3, t)) begin
                    errors++;
                    $display("FAIL rml_data t=%0d: got a=%h b=%h want a=%h b=%h", t, cap_a[t], cap_b[t], exp_a(3, t), exp_b(3, t));
                end
            end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.in_valid = 1'b0;
        bus_if.in_a_row = '0;
        bus_if.in_b_row = '0;
        // Slots 0..3: distinct values 0x11.. for A and ..0x3C for B.
        for (int m = 0; m < 4; m++)
            for (int r = 0; r < 3; r++)
                for (int k = 0; k < 3; k++) begin
                    ma[m][r][k] = 8'(8'h11 + 9*m + 3*r + k);
                    mb[m][r][k] = 8'(8'h3C - (9*m + 3*r + k));
                end
        // Slot 4: worked example (A = 1..9, B = identity).
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 3; k++) begin
                ma[4][r][k] = 8'(3*r + k + 1);
                mb[4][r][k] = (r == k) ? 8'd1 : 8'd0;
                ma[5][r][k] = 8'(8'hA0 + 3*r + k);
                mb[5][r][k] = 8'(8'hC0 + 3*r + k);
            end

        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_gapped();
        test_reset_mid_stream();
        test_reset_mid_load();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/systolic_feeder_3x3.md
# systolic_feeder_3x3

Input skew and buffering stage that sits directly upstream of the 3x3 systolic array. It accepts operand matrices A and B one row per handshake beat into a ping-pong pair of banks. It then streams each loaded pair into the array as diagonally skewed lanes, so that element A[i][k] meets B[k][j] in the correct processing element. Loading the next matrix pair overlaps with streaming the current one, which gives back-to-back streams with no bubble.

## Interface
- DW, 8, operand element width; lane i occupies bits [i*DW +: DW] of every packed bus.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low; clears all state immediately when low.
- in_valid  in  1  row beat offered.
- in_ready  out  1  row beat can be accepted; combinational, equals "write bank not full".
- in_a_row  in  3*DW  row r of A; element k = A[r][k].
- in_b_row  in  3*DW  row r of B; element k = B[r][k].
- a_out  out  3*DW  lane i feeds array row i (A operand).
- b_out  out  3*DW  lane j feeds array column j (B operand).
- out_valid  out  1  a_out/b_out carry a stream step.
- out_first  out  1  step t=0 of a stream.
- out_last  out  1  step t=4 of a stream.
- busy  out  1  a stream is in progress or a bank is full.

## Operation
- Storage: two banks, each holding 3 A rows and 3 B rows, with a full flag per bank. Pointers: wr_bank, rd_bank, row_cnt (0..2), step t (0..4).
- Load: a beat is accepted when in_valid and in_ready are both high. The beat writes row row_cnt of bank wr_bank, then row_cnt increments. On the third beat (row_cnt==2), the bank's full flag is set, row_cnt wraps to 0 and wr_bank toggles.
- Streamer FSM:
  - IDLE: if full[rd_bank] is set, go to STREAM with t=0.
  - STREAM: at each step t, a_out lane i = A[i][t-i] and b_out lane j = B[t-j][j] when the index is in 0..2; otherwise the lane is 0.
  - At t=4: clear full[rd_bank] and toggle rd_bank. If the other bank is already full, continue directly with t=0 of the next stream. Otherwise return to IDLE.
- Output flags: out_valid is high on every STREAM step. out_first is high only at t=0 and out_last only at t=4. In IDLE, all data outputs are 0.
- busy = (state==STREAM) | full[0] | full[1].
- Simultaneous events: a load into one bank and streaming from the other bank proceed independently in the same cycle. The load and stream paths never touch the same bank. A bank freed at t=4 is writable from the next cycle, not the same cycle.
- No downstream backpressure: once a stream starts, it always runs all 5 steps.
- Reset (rst low), whether idle or mid-operation:
  - Full flags, pointers, row_cnt and t are cleared and the FSM goes to IDLE.
  - Every output goes to 0 immediately except in_ready, which reads 1.
  - Any partial bank or in-progress stream is discarded; bank contents need not be cleared.

## Timing
- Outputs a_out, b_out, out_valid, out_first and out_last are registered. in_ready is combinational from the full flags.
- Latency: if the third row beat of a pair is accepted at edge k and the streamer is idle, the full flag is set at edge k. The output shows t=0 after edge k+1 and t=4 after edge k+5.
- A stream occupies exactly 5 cycles. Back-to-back streams have no gap between the t=4 step and the next t=0 step.
- Sustained throughput: one matrix pair per 5 cycles. The loader needs 3 cycles per pair, so in_ready deasserts periodically.
- in_ready is low when full[wr_bank] is set, i.e. both banks are loaded and the current stream has not yet reached t=4. It rises the cycle after the t=4 step.

## Test plan
- Single pair:
  - Stimulus: A = [[1,2,3],[4,5,6],[7,8,9]], B = [[1,0,0],[0,1,0],[0,0,1]].
  - Required a_out (lane0,1,2) over t=0..4: (1,0,0), (2,4,0), (3,5,7), (0,6,8), (0,0,9).
  - Required b_out over t=0..4: (1,0,0), (0,0,0), (0,1,0), (0,0,0), (0,0,1).
  - out_first only at t=0, out_last only at t=4; t=0 appears one cycle after the third accepted beat.
- Back-to-back: load two pairs with in_valid held high. Required: 10 consecutive out_valid cycles, out_last then out_first on adjacent cycles, and the second stream carries the second pair's data.
- Backpressure: hold in_valid high for 12 beats. Required: in_ready drops after 6 accepted beats, and no beat is lost or duplicated. Check via the streamed values, using distinct row contents 0x11..0x3C.
- Gapped input: in_valid toggles 1/0 per cycle. Required: rows land in the correct order, and the stream starts one cycle after the third accepted beat.
- Reset mid-stream: drop rst at t=2. Required: all outputs 0 and in_ready=1 while rst is low. After release, a fresh pair streams correctly with no residue of the aborted data.
- Reset mid-load: drop rst after 2 beats. Required: the partial rows are discarded, and the next 3 beats form a complete new matrix.
